fifo_sync_ext: RTL and testbench

- Parametrised synchronous single-clock FIFO; next generation of the team's basic FIFO.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags with clear.
- Show-ahead read data.
- Sits between stream producers/consumers where backpressure decisions need early warning and protocol errors must be logged, not silently dropped.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_ptr.sv | 25 ++
 rtl/fifo_sync_ext.sv | 121 ++++++++++++
 tb/tb_fifo_sync_ext.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and status payload type for the fifo_sync_ext FIFO family.
package fifo_pkg;

  localparam int unsigned DEF_DEPTH_BW = 4;
  localparam int unsigned DEF_DATA_BW  = 8;

  // Status word for downstream status buses.
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: low bits index the memory, MSB is the wrap bit.
module fifo_ptr #(
  parameter int unsigned PTR_BW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  output logic [PTR_BW-1:0] ptr
);

  logic [PTR_BW-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = ptr_q + PTR_BW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_sync_ext.sv
// Single-clock show-ahead FIFO with occupancy, thresholds and sticky error flags.
// Define FIFO_PEAK_EN to add the peak (high-water mark) output.
module fifo_sync_ext
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH_BW = DEF_DEPTH_BW,
  parameter int unsigned DATA_BW  = DEF_DATA_BW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [DATA_BW-1:0]  wdata,
  input  logic                pop,
  output logic [DATA_BW-1:0]  rdata,
  output logic                empty,
  output logic                full,
  output logic [DEPTH_BW:0]   count,
  input  logic [DEPTH_BW:0]   af_level,
  input  logic [DEPTH_BW:0]   ae_level,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow,
  output logic                underflow,
  input  logic                clr_err
`ifdef FIFO_PEAK_EN
  ,
  output logic [DEPTH_BW:0]   peak
`endif
);

  localparam int unsigned PTR_BW = DEPTH_BW + 1;
  localparam int unsigned DEPTH  = 32'(1) << DEPTH_BW;

  logic [PTR_BW-1:0]  rd_ptr, wr_ptr;
  logic [PTR_BW-1:0]  count_d, count_q;
  logic               overflow_d, overflow_q;
  logic               underflow_d, underflow_q;
  logic               push_ok, pop_ok;
  logic [DATA_BW-1:0] mem_q [DEPTH];

  fifo_ptr #(.PTR_BW(PTR_BW)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (pop_ok),
    .ptr   (rd_ptr)
  );

  fifo_ptr #(.PTR_BW(PTR_BW)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (push_ok),
    .ptr   (wr_ptr)
  );

  // Flags come straight from the registered pointers and count.
  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[DEPTH_BW-1:0] == wr_ptr[DEPTH_BW-1:0]) &&
                 (rd_ptr[DEPTH_BW] != wr_ptr[DEPTH_BW]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + PTR_BW'(1);
      2'b01:   count_d = count_q - PTR_BW'(1);
      default: count_d = count_q;
    endcase
    // A rejection in the same cycle as clr_err leaves the flag set.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (push && full) overflow_d = 1'b1;
    if (pop && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr[DEPTH_BW-1:0]] <= wdata;
  end

  assign rdata        = mem_q[rd_ptr[DEPTH_BW-1:0]];
  assign count        = count_q;
  assign almost_full  = (af_level != '0) && (count_q >= af_level);
  assign almost_empty = (count_q <= ae_level);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

`ifdef FIFO_PEAK_EN
  logic [PTR_BW-1:0] peak_d, peak_q;

  // High-water mark restarts from the post-edge occupancy on clr_err.
  always_comb begin
    peak_d = peak_q;
    if (clr_err)                peak_d = count_d;
    else if (count_d > peak_q)  peak_d = count_d;
  end

  always_ff @(posedge clk) begin
    if (reset) peak_q <= '0;
    else       peak_q <= peak_d;
  end

  assign peak = peak_q;
`endif

endmodule

// File: tb/tb_fifo_sync_ext.sv
// Randomised and directed bench for fifo_sync_ext against a queue-based reference model.
module tb_fifo_sync_ext;

  localparam int unsigned DEPTH_BW = 2;
  localparam int unsigned DATA_BW  = 8;
  localparam int          DEPTH    = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               push, pop, clr_err;
  logic [DATA_BW-1:0] wdata;
  logic [DATA_BW-1:0] rdata;
  logic               empty, full, almost_full, almost_empty, overflow, underflow;
  logic [DEPTH_BW:0]  count, af_level, ae_level;
`ifdef FIFO_PEAK_EN
  logic [DEPTH_BW:0]  peak;
`endif

  always #5 clk = ~clk;

  fifo_sync_ext #(.DEPTH_BW(DEPTH_BW), .DATA_BW(DATA_BW)) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .wdata        (wdata),
    .pop          (pop),
    .rdata        (rdata),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .af_level     (af_level),
    .ae_level     (ae_level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
`ifdef FIFO_PEAK_EN
    ,
    .peak         (peak)
`endif
  );

  // Reference model state.
  logic [7:0] m_q[$];
  bit         m_ov, m_un;
  int         m_peak;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic void model_step(input bit p, input logic [7:0] d, input bit r,
                                     input bit c, input bit rs);
    bit was_full, was_empty;
    if (rs) begin
      m_q.delete();
      m_ov = 0; m_un = 0; m_peak = 0;
      return;
    end
    was_full  = (m_q.size() == DEPTH);
    was_empty = (m_q.size() == 0);
    if (r && !was_empty) void'(m_q.pop_front());
    if (p && !was_full)  m_q.push_back(d);
    m_ov = (p && was_full)  ? 1'b1 : (c ? 1'b0 : m_ov);
    m_un = (r && was_empty) ? 1'b1 : (c ? 1'b0 : m_un);
    if (c) m_peak = m_q.size();
    else if (m_q.size() > m_peak) m_peak = m_q.size();
  endfunction

  task automatic check_all();
    int n;
    n = m_q.size();
    check("count", 32'(count), 32'(n));
    check("empty", 32'(empty), 32'(n == 0));
    check("full", 32'(full), 32'(n == DEPTH));
    if (n != 0) check("rdata", 32'(rdata), 32'(m_q[0]));
    check("almost_full", 32'(almost_full), 32'((af_level != 0) && (n >= int'(af_level))));
    check("almost_empty", 32'(almost_empty), 32'(n <= int'(ae_level)));
    check("overflow", 32'(overflow), 32'(m_ov));
    check("underflow", 32'(underflow), 32'(m_un));
`ifdef FIFO_PEAK_EN
    check("peak", 32'(peak), 32'(m_peak));
`endif
  endtask

  task automatic cyc(input bit p, input logic [7:0] d, input bit r, input bit c, input bit rs);
    push = p; wdata = d; pop = r; clr_err = c; reset = rs;
    @(posedge clk);
    model_step(p, d, r, c, rs);
    #1;
    check_all();
  endtask

  initial begin
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    push = 0; pop = 0; clr_err = 0; reset = 1; wdata = '0;
    af_level = 3'd3; ae_level = 3'd1;

    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_almost_empty", 32'(almost_empty), 32'd1);

    // Fill to full, then overflow attempt.
    foreach (vals[i]) cyc(1, vals[i], 0, 0, 0);
    check("full_after_4", 32'(full), 32'd1);
    check("head_0x11", 32'(rdata), 32'h11);
    cyc(1, 8'h55, 0, 0, 0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd4);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      check("drain_head", 32'(rdata), 32'(vals[i]));
      cyc(0, 0, 1, 0, 0);
    end
    check("drained_empty", 32'(empty), 32'd1);

    // Push+pop while empty: pop rejected, push accepted.
    cyc(1, 8'hA5, 1, 0, 0);
    check("unf_set", 32'(underflow), 32'd1);
    check("unf_rdata", 32'(rdata), 32'hA5);
    cyc(0, 0, 0, 1, 0);
    check("unf_clr", 32'(underflow), 32'd0);
    cyc(0, 0, 1, 0, 0);

    // Threshold sweep, then af_level=0 at full.
    for (int i = 0; i < 4; i++) cyc(1, 8'(i + 1), 0, 0, 0);
    af_level = 3'd0;
    #1 check("af_disabled_full", 32'(almost_full), 32'd0);
    af_level = 3'd3;
    for (int i = 0; i < 2; i++) cyc(0, 0, 1, 0, 0);

    // Steady push+pop at count 2 across pointer wrap.
    for (int i = 0; i < 20; i++) cyc(1, 8'($urandom), 1, 0, 0);
    check("steady_count", 32'(count), 32'd2);

    // Reset mid-operation with a push pending.
    cyc(1, 8'h01, 0, 0, 0);
    cyc(1, 8'h02, 0, 0, 1);
    check("midrst_count", 32'(count), 32'd0);
    cyc(1, 8'h7E, 0, 0, 0);
    check("post_rst_rdata", 32'(rdata), 32'h7E);

    // Random traffic with alternating fill/drain bias and random thresholds.
    for (int i = 0; i < 400; i++) begin
      bit fill;
      fill = ((i / 40) % 2) == 0;
      if ($urandom_range(0, 7) == 0) af_level = 3'($urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) ae_level = 3'($urandom_range(0, 4));
      cyc(($urandom_range(0, 9) < (fill ? 8 : 3)),
          8'($urandom),
          ($urandom_range(0, 9) < (fill ? 3 : 8)),
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
